// File: rtl/rv32_fetch_pkg.sv
// rv32_fetch_pkg: shared widths, constants and parcel helpers for the fetch front end
package rv32_fetch_pkg;
  localparam int PARCEL_W = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;
  function automatic logic is_compressed(input logic [PARCEL_W-1:0] p);
    return p[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/rv32_parcel_fifo.sv
// rv32_parcel_fifo: circular halfword buffer with 0/1/2 parcel push and pop per cycle
module rv32_parcel_fifo
  import rv32_fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_i,
  input  logic [1:0]                push_n_i,
  input  logic [31:0]               push_d_i,
  input  logic [1:0]                pop_n_i,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic [PARCEL_W-1:0]       h0_o,
  output logic [PARCEL_W-1:0]       h1_o
);
  localparam int AW = $clog2(DEPTH);
  logic [PARCEL_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  // parcel storage; contents are meaningless outside [rd, rd+count) so no reset
  always_ff @(posedge clk) begin
    if (push_n_i != 2'd0) mem_q[wr_q] <= push_d_i[15:0];
    if (push_n_i == 2'd2) mem_q[wr_q + AW'(1)] <= push_d_i[31:16];
  end
  // pointer and occupancy next state; pointers wrap for free since DEPTH is a power of two
  always_comb begin
    wr_d  = clear_i ? '0 : wr_q + AW'(push_n_i);
    rd_d  = clear_i ? '0 : rd_q + AW'(pop_n_i);
    cnt_d = clear_i ? '0 : cnt_q + (AW+1)'(push_n_i) - (AW+1)'(pop_n_i);
  end
  // pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // the issue rule upstream must keep pushes within capacity and pops within occupancy
  always_ff @(posedge clk) begin
    if (!rst && !clear_i) begin
      assert (int'(cnt_q) + int'(push_n_i) <= DEPTH);
      assert (pop_n_i <= 2'(cnt_q > 1 ? 2 : cnt_q));
    end
  end
  assign count_o = cnt_q;
  assign h0_o = mem_q[rd_q];
  assign h1_o = mem_q[rd_q + AW'(1)];
endmodule

// File: rtl/rv32_fetch_queue.sv
// rv32_fetch_queue: pipelined instruction fetch with parcel queue and halfword alignment
module rv32_fetch_queue
  import rv32_fetch_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_is_comp
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [31:0] fetch_addr_q, fetch_addr_d, head_pc_q, head_pc_d;
  logic [2:0] out_cnt_q, out_cnt_d, drop_q, drop_d;
  logic skip_low_q, skip_low_d;
  logic [CW-1:0] count;
  logic [PARCEL_W-1:0] h0, h1;
  logic [1:0] push_n, pop_n;
  logic [31:0] push_d;
  logic comp, req, valid, fire, gnt, keep;
  rv32_parcel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (redirect_valid),
    .push_n_i (push_n),
    .push_d_i (push_d),
    .pop_n_i  (pop_n),
    .count_o  (count),
    .h0_o     (h0),
    .h1_o     (h1)
  );
  // issue, response, alignment and redirect next-state; redirect overrides everything
  always_comb begin
    comp  = is_compressed(h0);
    valid = !rst && !redirect_valid && count != '0 && (comp || count >= CW'(2));
    req   = !rst && !redirect_valid && int'(out_cnt_q) < MAX_OUT &&
            (DEPTH - int'(count)) >= 2 * (int'(out_cnt_q) + 1);
    fire  = valid && out_ready;
    gnt   = req && imem_gnt;
    keep  = imem_rvalid && !redirect_valid && drop_q == '0;
    pop_n  = fire ? (comp ? 2'd1 : 2'd2) : 2'd0;
    push_n = keep ? (skip_low_q ? 2'd1 : 2'd2) : 2'd0;
    push_d = skip_low_q ? {16'h0, imem_rdata[31:16]} : imem_rdata;
    out_cnt_d    = out_cnt_q + 3'(gnt) - 3'(imem_rvalid);
    drop_d       = redirect_valid ? out_cnt_q - 3'(imem_rvalid)
                                  : drop_q - 3'(imem_rvalid && drop_q != '0);
    skip_low_d   = redirect_valid ? redirect_pc[1] : skip_low_q && !keep;
    fetch_addr_d = redirect_valid ? redirect_pc : fetch_addr_q + (gnt ? 32'd4 : 32'd0);
    head_pc_d    = redirect_valid ? redirect_pc : head_pc_q + {29'd0, pop_n, 1'b0};
    imem_req    = req;
    imem_addr   = rst ? '0 : {fetch_addr_q[31:2], 2'b00};
    out_valid   = valid;
    out_inst    = rst ? '0 : (comp ? {16'h0, h0} : {h1, h0});
    out_pc      = rst ? '0 : head_pc_q;
    out_is_comp = !rst && comp;
  end
  // fetch state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_addr_q <= RESET_PC;
      head_pc_q    <= RESET_PC;
      out_cnt_q    <= '0;
      drop_q       <= '0;
      skip_low_q   <= RESET_PC[1];
    end else begin
      fetch_addr_q <= fetch_addr_d;
      head_pc_q    <= head_pc_d;
      out_cnt_q    <= out_cnt_d;
      drop_q       <= drop_d;
      skip_low_q   <= skip_low_d;
    end
  end
endmodule

// File: tb/tb_rv32_fetch_queue.sv
// tb_rv32_fetch_queue: directed and random fetch traffic checked against a PC-walking program model
module tb_rv32_fetch_queue;
  localparam int DEPTH = 8;
  localparam int MAX_OUT = 2;
  localparam logic [31:0] RESET_PC = 32'h0;
  logic clk = 0, rst = 1, redirect_valid = 0, imem_gnt = 0, imem_rvalid = 0, out_ready = 0;
  logic [31:0] redirect_pc = '0, imem_rdata = '0;
  logic imem_req, out_valid, out_is_comp;
  logic [31:0] imem_addr, out_inst, out_pc;
  int checks = 0, failures = 0;
  logic [31:0] mem [256];
  logic [7:0] pend[$];
  int gnt_pct = 100, rv_pct = 100, grants = 0, nfire = 0, g0, n0;
  bit gnt_en = 1, hold_rv = 0;
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] log_pc[$], log_inst[$];
  logic log_comp[$];
  logic s_valid, s_req;
  logic [31:0] s_addr, s_pc;

  always #5 clk = ~clk;

  rv32_fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .out_is_comp(out_is_comp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] parcel(input logic [31:0] pc);
    logic [31:0] w;
    w = mem[pc[9:2]];
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  // one clock: memory responder, then scoreboard, then wait for the next falling edge
  task automatic cycle();
    logic [15:0] p0;
    logic [31:0] exp;
    logic c;
    #1;
    if (rst) begin
      pend.delete();
      imem_rvalid = 0;
      imem_gnt = 0;
      imem_rdata = '0;
    end else begin
      imem_rvalid = pend.size() != 0 && !hold_rv && $urandom_range(99) < rv_pct;
      if (imem_rvalid) imem_rdata = mem[pend.pop_front()];
      else imem_rdata = '0;
      imem_gnt = gnt_en && $urandom_range(99) < gnt_pct;
    end
    #1;
    s_valid = out_valid; s_req = imem_req; s_addr = imem_addr; s_pc = out_pc;
    if (rst) begin
      model_pc = RESET_PC;
      log_pc.delete(); log_inst.delete(); log_comp.delete();
    end else begin
      if (imem_req && imem_gnt) begin
        pend.push_back(imem_addr[9:2]);
        grants++;
      end
      check("outstanding_le_max", 32'(pend.size() <= MAX_OUT), 1);
      if (redirect_valid) begin
        check("redirect_no_valid", 32'(out_valid), 0);
        model_pc = redirect_pc;
      end else if (out_valid && out_ready) begin
        p0 = parcel(model_pc);
        c = p0[1:0] != 2'b11;
        exp = c ? {16'h0, p0} : {parcel(model_pc + 2), p0};
        check("out_pc", out_pc, model_pc);
        check("out_inst", out_inst, exp);
        check("out_is_comp", 32'(out_is_comp), 32'(c));
        log_pc.push_back(out_pc); log_inst.push_back(out_inst); log_comp.push_back(out_is_comp);
        nfire++;
        model_pc = model_pc + (c ? 32'd2 : 32'd4);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0041_0113;
    mem[1] = 32'h4505_4501;
    mem[8'h41] = {16'h4505, mem[8'h41][15:0]};
    // reset state
    cycle(); cycle();
    check("rst_out_valid", 32'(s_valid), 0);
    check("rst_imem_req", 32'(s_req), 0);
    check("rst_imem_addr", s_addr, 0);
    check("rst_out_pc", s_pc, 0);
    check("rst_out_inst", out_inst, 0);
    rst = 0; out_ready = 1;
    cycle();
    check("req_after_reset", 32'(s_req), 1);
    check("addr_after_reset", s_addr, RESET_PC);
    repeat (10) cycle();
    // mixed 32-bit and compressed stream
    check("t1_fire_count", 32'(log_pc.size() >= 3), 1);
    if (log_pc.size() >= 3) begin
      check("t1_pc0", log_pc[0], 32'h0);
      check("t1_pc1", log_pc[1], 32'h4);
      check("t1_pc2", log_pc[2], 32'h6);
      check("t1_comp0", 32'(log_comp[0]), 0);
      check("t1_comp1", 32'(log_comp[1]), 1);
      check("t1_comp2", 32'(log_comp[2]), 1);
      check("t1_inst0", log_inst[0], 32'h0041_0113);
      check("t1_inst1", log_inst[1], 32'h0000_4501);
    end
    // 32-bit instruction straddling a word boundary
    rst = 1;
    mem[0] = 32'h0513_0001;
    mem[1] = {mem[1][31:16], 16'h0000};
    cycle();
    rst = 0;
    repeat (10) cycle();
    check("t2_fire_count", 32'(log_pc.size() >= 2), 1);
    if (log_pc.size() >= 2) begin
      check("t2_pc0", log_pc[0], 32'h0);
      check("t2_inst0", log_inst[0], 32'h0000_0001);
      check("t2_pc1", log_pc[1], 32'h2);
      check("t2_inst1", log_inst[1], 32'h0000_0513);
      check("t2_comp1", 32'(log_comp[1]), 0);
    end
    // redirect with two reads outstanding and one returning in the redirect cycle
    rst = 1; hold_rv = 1;
    cycle();
    rst = 0;
    repeat (3) cycle();
    check("t3_two_outstanding", pend.size(), 2);
    redirect_valid = 1; redirect_pc = 32'h106; hold_rv = 0;
    cycle();
    check("t3_n0_valid", 32'(s_valid), 0);
    check("t3_n0_req", 32'(s_req), 0);
    redirect_valid = 0;
    cycle();
    check("t3_n1_req", 32'(s_req), 1);
    check("t3_n1_addr", s_addr, 32'h104);
    check("t3_n1_valid", 32'(s_valid), 0);
    cycle();
    check("t3_n2_valid", 32'(s_valid), 0);
    cycle();
    check("t3_n3_valid", 32'(s_valid), 1);
    check("t3_n3_pc", s_pc, 32'h106);
    repeat (10) cycle();
    // decode stalled: queue fills to DEPTH and requests stop
    rst = 1; out_ready = 0;
    cycle();
    rst = 0;
    g0 = grants;
    repeat (20) cycle();
    check("t4_grants", grants - g0, DEPTH / 2);
    check("t4_req_stopped", 32'(s_req), 0);
    check("t4_valid_held", 32'(s_valid), 1);
    check("t4_no_fire", log_pc.size(), 0);
    out_ready = 1;
    repeat (20) cycle();
    check("t4_drained", 32'(log_pc.size() >= DEPTH / 2), 1);
    if (log_pc.size() != 0) check("t4_first_pc", log_pc[0], RESET_PC);
    // grant withheld: request and address hold steady
    rst = 1; gnt_en = 0;
    cycle();
    rst = 0;
    repeat (5) begin
      cycle();
      check("t5_req_held", 32'(s_req), 1);
      check("t5_addr_held", s_addr, RESET_PC);
    end
    check("t5_none_outstanding", pend.size(), 0);
    gnt_en = 1;
    repeat (10) cycle();
    check("t5_progress", 32'(log_pc.size() != 0), 1);
    // asynchronous reset mid-stream
    gnt_pct = 70; rv_pct = 70;
    repeat (15) cycle();
    rst = 1;
    #1;
    check("t6_valid_async", 32'(out_valid), 0);
    check("t6_req_async", 32'(imem_req), 0);
    cycle();
    rst = 0;
    repeat (15) cycle();
    check("t6_fire_after_reset", 32'(log_pc.size() != 0), 1);
    if (log_pc.size() != 0) check("t6_first_pc", log_pc[0], RESET_PC);
    // random traffic with stalls, slow memory and redirects
    n0 = nfire;
    repeat (600) begin
      out_ready = $urandom_range(3) != 0;
      redirect_valid = $urandom_range(39) == 0;
      redirect_pc = {22'h0, 9'($urandom_range(511)), 1'b0};
      cycle();
    end
    redirect_valid = 0;
    check("rand_throughput", 32'(nfire - n0 >= 100), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
